// File: rtl/dmem_pkg.sv
// Shared definitions for the MIPS-54 data-memory controller: access size codes,
// controller state encoding and the default data-segment base address.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACCESS,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between the right-justified CPU data and one
// little-endian 32-bit storage word, plus the alignment check for the access.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wlane      = 32'h0;
    rdata      = 32'h0;
    rbyte      = rword[{byte_off, 3'b000} +: 8];
    rhalf      = byte_off[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << byte_off;
        wlane = {4{wdata[7:0]}};
        rdata = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        misaligned = byte_off[0];
        be         = byte_off[1] ? 4'b1100 : 4'b0011;
        wlane      = {2{wdata[15:0]}};
        rdata      = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        misaligned = (byte_off != 2'b00);
        be         = 4'b1111;
        wlane      = wdata;
        rdata      = rword;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multicycle data-segment memory with a req/ready/done handshake, programmable
// wait states, and error reporting for misaligned or out-of-range accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int          DEPTH_BYTES = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;

  dmem_state_t state, state_next;

  logic [3:0]    cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic [31:0]   off_q;
  logic [31:0]   wdata_q;

  logic [7:0]    mem [DEPTH_BYTES];

  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic          out_of_range;
  logic          misaligned;
  logic          access_err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   load_data;

  // Offsets below the base wrap to huge values, so one compare covers both ends.
  assign out_of_range = (off_q >= 32'(DEPTH_BYTES));
  assign access_err   = out_of_range | misaligned;
  assign word_idx     = off_q[AW-1:0] & ~AW'(3);
  assign rword        = {mem[word_idx + AW'(3)], mem[word_idx + AW'(2)],
                         mem[word_idx + AW'(1)], mem[word_idx]};

  dmem_lane_align u_align (
    .size       (size_q),
    .sign_ext   (sign_q),
    .byte_off   (off_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .misaligned (misaligned),
    .be         (be),
    .wlane      (wlane),
    .rdata      (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (WAIT_CYCLES > 0) ? BUSY : ACCESS;
      BUSY:    if (cnt == 4'd0) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      off_q   <= 32'h0;
      wdata_q <= 32'h0;
      rdata   <= 32'h0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        sign_q  <= sign_ext;
        off_q   <= addr - BASE_ADDR;
        wdata_q <= wdata;
        cnt     <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS) begin
        err   <= access_err;
        rdata <= (access_err || we_q) ? 32'h0 : load_data;
      end
    end
  end

  // Storage has no reset; an aborted access never reaches ACCESS, so nothing commits.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !access_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[word_idx + AW'(k)] <= wlane[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a WAIT_CYCLES=1 instance for the functional
// scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;

  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err;
  logic [31:0] rdata;

  logic        req0, we0, sign_ext0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0;
  logic        ready0, done0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .err(err)
  );

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .size(size0), .sign_ext(sign_ext0),
    .addr(addr0), .wdata(wdata0), .ready(ready0), .done(done0), .rdata(rdata0), .err(err0)
  );

  // Issues one request on the WAIT_CYCLES=1 instance; lat counts edges after accept, -1 on timeout.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic e, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; rd = 32'hxxxx_xxxx; e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_after_reset: done=%b ready=%b want 0/1", done, ready); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b1, SZ_WORD, 1'b0, BASE, 32'h8899AABB, rd, e, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL sw_latency: got %0d want 2", lat); end
    total++; if (e !== 1'b0 || rd !== 32'h0) begin bad++; $display("[TB] FAIL sw_resp: err=%b rdata=%h want 0/0", e, rd); end
    do_access(1'b0, SZ_WORD, 1'b0, BASE, 32'h0, rd, e, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL lw_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'h8899AABB || e !== 1'b0) begin bad++; $display("[TB] FAIL lw_data: got %h err=%b want 8899aabb/0", rd, e); end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_one_cycle: got %b want 0", done); end
    total++; if (rdata !== 32'h8899AABB) begin bad++; $display("[TB] FAIL rdata_hold: got %h want 8899aabb", rdata); end
  endtask

  task automatic test_sub_word();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b1, SZ_BYTE, 1'b0, BASE + 32'd1, 32'hFFFFFF7F, rd, e, lat);
    total++; if (lat !== 2 || e !== 1'b0) begin bad++; $display("[TB] FAIL sb_resp: lat=%0d err=%b want 2/0", lat, e); end
    do_access(1'b0, SZ_BYTE, 1'b1, BASE + 32'd3, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hFFFFFF88) begin bad++; $display("[TB] FAIL lb_signed: got %h want ffffff88", rd); end
    do_access(1'b0, SZ_BYTE, 1'b0, BASE + 32'd3, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h00000088) begin bad++; $display("[TB] FAIL lbu: got %h want 00000088", rd); end
    do_access(1'b0, SZ_HALF, 1'b0, BASE, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h00007FBB) begin bad++; $display("[TB] FAIL lhu: got %h want 00007fbb", rd); end
    do_access(1'b0, SZ_HALF, 1'b1, BASE + 32'd2, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hFFFF8899) begin bad++; $display("[TB] FAIL lh_signed: got %h want ffff8899", rd); end
    do_access(1'b0, SZ_BYTE, 1'b1, BASE + 32'd1, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h0000007F) begin bad++; $display("[TB] FAIL lb_positive: got %h want 0000007f", rd); end
  endtask

  task automatic test_top_boundary();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b1, SZ_WORD, 1'b0, BASE + 32'h3FC, 32'hA1B2C3D4, rd, e, lat);
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL sw_top_err: got %b want 0", e); end
    do_access(1'b0, SZ_BYTE, 1'b1, BASE + 32'h3FF, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hFFFFFFA1 || e !== 1'b0) begin bad++; $display("[TB] FAIL lb_last_byte: got %h err=%b want ffffffa1/0", rd, e); end
    do_access(1'b1, SZ_HALF, 1'b0, BASE + 32'h3FE, 32'h123455AA, rd, e, lat);
    do_access(1'b0, SZ_WORD, 1'b0, BASE + 32'h3FC, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h55AAC3D4) begin bad++; $display("[TB] FAIL sh_lanes: got %h want 55aac3d4", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b1, SZ_WORD, 1'b0, BASE, 32'h8899AABB, rd, e, lat);
    do_access(1'b0, SZ_WORD, 1'b0, BASE + 32'd2, 32'h0, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 2) begin bad++; $display("[TB] FAIL lw_misaligned: err=%b rdata=%h lat=%0d want 1/0/2", e, rd, lat); end
    do_access(1'b1, SZ_WORD, 1'b0, BASE + 32'h400, 32'hDEADBEEF, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL sw_out_of_range: err=%b rdata=%h want 1/0", e, rd); end
    do_access(1'b0, SZ_WORD, 1'b0, 32'h1000FFFC, 32'h0, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL lw_below_base: err=%b rdata=%h want 1/0", e, rd); end
    do_access(1'b1, SZ_HALF, 1'b0, BASE + 32'd1, 32'h00001111, rd, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL sh_misaligned: err=%b want 1", e); end
    do_access(1'b1, SZ_RSVD, 1'b0, BASE, 32'h22222222, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL size_reserved: err=%b rdata=%h want 1/0", e, rd); end
    do_access(1'b0, SZ_WORD, 1'b0, BASE, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h8899AABB || e !== 1'b0) begin bad++; $display("[TB] FAIL after_errors: got %h err=%b want 8899aabb/0", rd, e); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    @(negedge clk);
    we0 = 1'b1; size0 = SZ_WORD; sign_ext0 = 1'b0; addr0 = BASE + 32'd4; wdata0 = 32'h13579BDF;
    req0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) req0 = 1'b0;
      total++; if (done0 !== ((k % 3) == 1)) begin bad++; $display("[TB] FAIL b2b_done_%0d: got %b want %b", k, done0, (k % 3) == 1); end
      total++; if (ready0 !== ((k % 3) == 2)) begin bad++; $display("[TB] FAIL b2b_ready_%0d: got %b want %b", k, ready0, (k % 3) == 2); end
      if (done0 === 1'b1) pulses++;
    end
    total++; if (pulses !== 4) begin bad++; $display("[TB] FAIL b2b_pulse_count: got %0d want 4", pulses); end
    @(negedge clk);
    we0 = 1'b0; req0 = 1'b1;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(posedge clk);
    #1;
    total++; if (done0 !== 1'b1 || rdata0 !== 32'h13579BDF || err0 !== 1'b0) begin bad++; $display("[TB] FAIL w0_load: done=%b rdata=%h err=%b want 1/13579bdf/0", done0, rdata0, err0); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat;
    int seen = 0;
    @(negedge clk);
    we = 1'b1; size = SZ_WORD; sign_ext = 1'b0; addr = BASE; wdata = 32'hCAFEF00D; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: ready=%b want 0", ready); end
    rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1 || done !== 1'b0 || rdata !== 32'h0) begin bad++; $display("[TB] FAIL abort_idle: ready=%b done=%b rdata=%h want 1/0/0", ready, done, rdata); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL abort_no_done: saw %0d done cycles want 0", seen); end
    do_access(1'b0, SZ_WORD, 1'b0, BASE, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h8899AABB || e !== 1'b0) begin bad++; $display("[TB] FAIL abort_not_committed: got %h err=%b want 8899aabb/0", rd, e); end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = BASE; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; size0 = SZ_WORD; sign_ext0 = 1'b0; addr0 = BASE; wdata0 = 32'h0;
    $display("[TB] starting dmem_ctrl bench");
    test_reset();
    test_store_load();
    test_sub_word();
    test_top_boundary();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
